// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic ops plus iterative unsigned
// shift-add multiply and restoring divide behind a valid/ready handshake.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zf,
  output logic             ovf,
  output logic             dz
);

  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_MUL  = 6'h18;
  localparam logic [5:0] OP_DIVU = 6'h1B;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SDW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [5:0]       op_reg;
  // opnd_reg holds the multiplicand (MUL) or divisor (DIVU);
  // hi_reg/lo_reg form the shared 2*WIDTH working register.
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (opcode)
      OP_LDW, OP_SDW: sc_res = sum;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_BEQ: sc_res = diff;
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_JUMP: sc_res = a;
      default: sc_res = '0;
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // One iteration: shift-add for MUL, one restoring quotient bit for DIVU.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_sub   = div_shift - {1'b0, opnd_reg};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    if (op_reg == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_reg[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      opnd_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zf        <= 1'b1;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg   <= opcode;
            in_ready <= 1'b0;
            cnt_reg  <= '0;
            if (opcode == OP_MUL) begin
              opnd_reg  <= a;
              hi_reg    <= '0;
              lo_reg    <= b;
              state_reg <= CALC;
            end else if (opcode == OP_DIVU && b != '0) begin
              opnd_reg  <= b;
              hi_reg    <= '0;
              lo_reg    <= a;
              state_reg <= CALC;
            end else if (opcode == OP_DIVU) begin
              result    <= '1;
              result_hi <= a;
              zf        <= 1'b0;
              ovf       <= 1'b0;
              dz        <= 1'b1;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              result    <= sc_res;
              result_hi <= '0;
              zf        <= (sc_res == '0);
              ovf       <= sc_ovf;
              dz        <= 1'b0;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        CALC: begin
          hi_reg  <= step_hi;
          lo_reg  <= step_lo;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            // For both ops the final lo half is the primary result.
            result    <= step_lo;
            result_hi <= step_hi;
            zf        <= (step_lo == '0);
            ovf       <= 1'b0;
            dz        <= 1'b0;
            out_valid <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: hand-computed vectors for each op class,
// handshake stall behaviour, latency, divide-by-zero and mid-operation reset.
module tb_multicycle_alu;

  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_MUL  = 6'h18;
  localparam logic [5:0] OP_DIVU = 6'h1B;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_SLT  = 6'h2A;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zf;
  logic        ovf;
  logic        dz;

  int n_checks;
  int n_errors;
  int lat;

  multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zf(zf), .ovf(ovf), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with in_ready=1; returns with out_valid seen (or budget gone).
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] av,
                        input logic [31:0] bv);
    opcode   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn %s op=%0h a=%0h b=%0h lat=%0d result=%0h result_hi=%0h zf=%0b ovf=%0b dz=%0b",
             tag, op, av, bv, lat, result, result_hi, zf, ovf, dz);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hold_res;
    int          stale;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_zf", zf, 1);
    check("rst_ovf_dz", {ovf, dz}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_lat", lat, 1);
    check("add_res", result, 32'h8000_0000);
    check("add_ovf", ovf, 1);
    check("add_zf", zf, 0);
    check("add_hi", result_hi, 0);
    pop();
    check("add_pop_ready", in_ready, 1);
    check("add_pop_valid", out_valid, 0);

    // Stall the consumer; a new request during DONE must be ignored.
    run_op("sub_stall", OP_SUB, 32'd5, 32'd5);
    check("sub_lat", lat, 1);
    check("sub_res", result, 0);
    check("sub_zf", zf, 1);
    check("sub_ovf", ovf, 0);
    opcode = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("sub_hold_valid", out_valid, 1);
      check("sub_hold_res", result, 0);
      check("sub_hold_zf", zf, 1);
      check("sub_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    pop();
    check("sub_pop_ready", in_ready, 1);

    run_op("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2);
    check("mul_lat", lat, 33);
    check("mul_lo", result, 32'hFFFF_FFFE);
    check("mul_hi", result_hi, 32'h1);
    check("mul_flags", {zf, ovf, dz}, 0);
    pop();

    run_op("mul2", OP_MUL, 32'h1234_5678, 32'h0001_0000);
    check("mul2_lo", result, 32'h5678_0000);
    check("mul2_hi", result_hi, 32'h0000_1234);
    pop();

    run_op("divu", OP_DIVU, 32'd100, 32'd7);
    check("divu_lat", lat, 33);
    check("divu_q", result, 14);
    check("divu_r", result_hi, 2);
    check("divu_dz", dz, 0);
    pop();

    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000);
    check("divu_big_q", result, 32'h0000_FFFF);
    check("divu_big_r", result_hi, 32'h0000_FFFF);
    pop();

    run_op("divu_dz", OP_DIVU, 32'd9, 32'd0);
    check("dz_lat", lat, 1);
    check("dz_q", result, 32'hFFFF_FFFF);
    check("dz_r", result_hi, 9);
    check("dz_flag", dz, 1);
    pop();

    run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1);
    check("slt_res", result, 1);
    pop();
    run_op("slt_neg", OP_SLT, 32'd1, 32'hFFFF_FFFF);
    check("slt_neg_res", result, 0);
    check("slt_neg_zf", zf, 1);
    pop();
    run_op("and", OP_AND, 32'hF0F0_F0F0, 32'hFFFF_0000);
    check("and_res", result, 32'hF0F0_0000);
    pop();
    run_op("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF);
    check("xor_res", result, 32'h5555_AAAA);
    pop();
    run_op("ldw", OP_LDW, 32'hFFFF_FFF0, 32'h20);
    check("ldw_res", result, 32'h10);
    check("ldw_ovf", ovf, 0);
    pop();
    run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1);
    check("sub_ovf_res", result, 32'h7FFF_FFFF);
    check("sub_ovf_flag", ovf, 1);
    pop();
    run_op("jump", OP_JUMP, 32'hDEAD_BEEF, 32'd3);
    check("jump_res", result, 32'hDEAD_BEEF);
    pop();
    run_op("undef", 6'h3F, 32'h1234, 32'h5678);
    check("undef_res", result, 0);
    check("undef_zf", zf, 1);
    pop();

    // Reset during CALC cycle 10 of a multiply.
    opcode = OP_MUL; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", out_valid, 0);
    check("rstmid_ready", in_ready, 1);
    check("rstmid_res", result, 0);
    check("rstmid_zf", zf, 1);
    #4;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("rstmid_stale", stale, 0);
    run_op("add_after_rst", OP_ADD, 32'd2, 32'd3);
    check("post_rst_lat", lat, 1);
    check("post_rst_res", result, 5);
    hold_res = result;
    pop();
    check("post_rst_pop", {in_ready, out_valid}, 2'b10);
    check("post_rst_keep", hold_res, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter CNT_W, default 6, iteration counter width; it SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operation request.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have port opcode, input, 6, operation select, decoded with the shared opcode macros: LDW, SDW, BEQ, ADD, SUB, AND, OR, XOR, SLT, JUMP, plus new macros MUL and DIVU.
REQ-008 The block SHALL have ports a and b, input, WIDTH each, operands (a = rs, b = rt or imm).
REQ-009 The block SHALL have port out_valid, output, 1, result available.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 The block SHALL have port result, output, WIDTH, primary result (product low half, or quotient).
REQ-012 The block SHALL have port result_hi, output, WIDTH, product high half or remainder; 0 for all other ops.
REQ-013 The block SHALL have ports zf, ovf and dz, output, 1 each: result==0; signed overflow on ADD/SUB; divide-by-zero.

Function
REQ-014 The block SHALL accept a request on a rising edge when in_valid and in_ready are both 1; it SHALL capture a, b and opcode on that edge.
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 The FSM SHALL transition IDLE -> DONE on accepting a single-cycle op, and IDLE -> CALC on accepting MUL or DIVU with a nonzero divisor.
REQ-017 The FSM SHALL transition CALC -> DONE after exactly WIDTH iteration edges.
REQ-018 The FSM SHALL transition DONE -> IDLE on an edge where out_ready is 1.
REQ-019 Single-cycle ops SHALL set out_valid=1 immediately after the accept edge (latency 1).
REQ-020 MUL and DIVU SHALL set out_valid=1 after accept edge + WIDTH edges (latency WIDTH+1).
REQ-021 While out_valid=1, result, result_hi, zf, ovf and dz SHALL remain stable until the edge where out_ready is 1.
REQ-022 out_ready sampled while out_valid=0 SHALL be ignored; in_valid outside IDLE SHALL be ignored.
REQ-023 LDW, SDW and ADD SHALL compute a+b mod 2^WIDTH.
REQ-024 SUB and BEQ SHALL compute a-b mod 2^WIDTH.
REQ-025 AND, OR and XOR SHALL be bitwise over the full WIDTH with no masking.
REQ-026 SLT SHALL be a signed compare giving 1 or 0.
REQ-027 JUMP SHALL return a; undefined opcodes SHALL return 0.
REQ-028 MUL SHALL be unsigned shift-add producing a 2*WIDTH product {result_hi, result}, one partial-product step per CALC cycle.
REQ-029 DIVU SHALL be unsigned restoring division with one quotient bit per CALC cycle: result = a/b, result_hi = a%b.
REQ-030 DIVU with b==0 SHALL go IDLE -> DONE with latency 1, result all ones, result_hi = a, dz=1.
REQ-031 zf SHALL reflect result only (WIDTH bits; result_hi excluded).
REQ-032 ovf SHALL be 1 only for ADD/SUB when operand signs and result sign indicate signed overflow; it SHALL be 0 for all other ops.
REQ-033 dz SHALL be 0 except in the REQ-030 case.

Reset
REQ-034 rst_n=0 SHALL, at any time including mid-CALC or in DONE, immediately force state=IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, zf=1, ovf=0, dz=0 and counter=0, abandoning any operation in flight.
REQ-035 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-036 Bench SHALL cover: ADD a=0x7FFFFFFF, b=1 -> one cycle later out_valid=1, result=0x80000000, ovf=1, zf=0.
REQ-037 Bench SHALL cover: SUB a=5, b=5 with out_ready held 0 for 3 cycles -> result=0, zf=1, outputs stable, in_ready=0 until the out_ready edge.
REQ-038 Bench SHALL cover: MUL a=0xFFFFFFFF, b=2 -> out_valid exactly 33 edges after accept, result=0xFFFFFFFE, result_hi=0x00000001.
REQ-039 Bench SHALL cover: DIVU a=100, b=7 -> latency 33, result=14, result_hi=2, dz=0; and DIVU b=0, a=9 -> latency 1, result=0xFFFFFFFF, result_hi=9, dz=1.
REQ-040 Bench SHALL cover: SLT a=0xFFFFFFFF (-1), b=1 -> result=1; AND a=0xF0F0F0F0, b=0xFFFF0000 -> 0xF0F00000.
REQ-041 Bench SHALL cover: rst_n pulsed low at CALC cycle 10 of a MUL -> out_valid=0 and in_ready=1 at once, no stale result afterwards, next ADD 2+3 -> 5.
